// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its helpers.
package instr_fetch_unit_pkg;

  // Fetch FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_VALID = 3'd2,
    ST_UPD   = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  // Sticky fault cause reported on fault_code
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  // Default sequential PC increment in bytes
  localparam int unsigned PC_STEP_DEF = 4;

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC selection: redirect target when a redirect is in effect,
// otherwise the sequential successor (wraps modulo 2^ADDR_W).
module next_pc_select
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PC_STEP = PC_STEP_DEF
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_next_pc
);

  // Pure mux; the adder carry-out is dropped so the PC wraps
  always_comb begin
    o_next_pc = i_redirect ? i_target : (i_pc + ADDR_W'(PC_STEP));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: requests the word at pc from instruction memory,
// hands it to decode, then loads the next PC into the program counter.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_STEP = PC_STEP_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  PCin,
  output logic               updatePC,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t       r_state;
  logic               r_imem_req;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_instr_valid;
  logic [ADDR_W-1:0]  r_pc_in;
  logic               r_update_pc;
  logic               r_fault;
  logic [1:0]         r_fault_code;
  logic               r_redir_pend;
  logic [ADDR_W-1:0]  r_redir_tgt;
  logic [CNT_W-1:0]   r_wait_cnt;

  logic               w_redir_eff;
  logic [ADDR_W-1:0]  w_redir_tgt;
  logic [ADDR_W-1:0]  w_next_pc;
  logic [CNT_W-1:0]   w_wait_inc;

  // A redirect arriving this cycle takes precedence over an older pending one
  always_comb begin
    w_redir_eff = redirect | r_redir_pend;
    w_redir_tgt = redirect ? redirect_target : r_redir_tgt;
    w_wait_inc  = r_wait_cnt + CNT_W'(1);
  end

  next_pc_select #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .i_pc       (pc),
    .i_redirect (w_redir_eff),
    .i_target   (w_redir_tgt),
    .o_next_pc  (w_next_pc)
  );

  // Fetch FSM with registered outputs
  // NOTE: every register here, including the instruction latch, is reset so
  // decode never sees stale data; all state updates use non-blocking '<='.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_pc_in       <= '0;
      r_update_pc   <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= FC_NONE;
      r_redir_pend  <= 1'b0;
      r_redir_tgt   <= '0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (redirect) begin
            r_pc_in     <= w_next_pc;
            r_update_pc <= 1'b1;
            r_state     <= ST_UPD;
          end else if (fetch_en) begin
            if (pc[1:0] != 2'b00) begin
              r_fault      <= 1'b1;
              r_fault_code <= FC_MISALIGN;
              r_state      <= ST_FAULT;
            end else begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= pc;
              r_wait_cnt  <= '0;
              r_state     <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (redirect) begin
            r_redir_pend <= 1'b1;
            r_redir_tgt  <= redirect_target;
          end
          if (imem_ready) begin
            r_imem_req <= 1'b0;
            if (w_redir_eff) begin
              // Word belongs to the squashed path; drop it
              r_pc_in     <= w_next_pc;
              r_update_pc <= 1'b1;
              r_state     <= ST_UPD;
            end else begin
              r_instr       <= imem_rdata;
              r_instr_pc    <= r_imem_addr;
              r_instr_valid <= 1'b1;
              r_state       <= ST_VALID;
            end
          end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == CNT_W'(TIMEOUT)) begin
              r_imem_req   <= 1'b0;
              r_fault      <= 1'b1;
              r_fault_code <= FC_TIMEOUT;
              r_state      <= ST_FAULT;
            end
          end
        end

        ST_VALID: begin
          if (redirect) begin
            r_redir_pend <= 1'b1;
            r_redir_tgt  <= redirect_target;
          end
          if (id_ready) begin
            r_instr_valid <= 1'b0;
            r_pc_in       <= w_next_pc;
            r_update_pc   <= 1'b1;
            r_state       <= ST_UPD;
          end
        end

        ST_UPD: begin
          r_redir_pend <= 1'b0;
          r_wait_cnt   <= '0;
          if (redirect) begin
            // Late redirect: one more UPD pass loads its target over ours
            r_pc_in     <= w_next_pc;
            r_update_pc <= 1'b1;
            r_state     <= ST_UPD;
          end else begin
            r_update_pc <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        ST_FAULT: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_update_pc   <= 1'b0;
          r_fault       <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive ports straight from the output registers
  always_comb begin
    imem_req    = r_imem_req;
    imem_addr   = r_imem_addr;
    instr       = r_instr;
    instr_pc    = r_instr_pc;
    instr_valid = r_instr_valid;
    PCin        = r_pc_in;
    updatePC    = r_update_pc;
    fault       = r_fault;
    fault_code  = r_fault_code;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for the basic fetch
// loop plus hand-written sequences for waits, redirects, faults and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        id_ready;
  logic [31:0] PCin;
  logic        updatePC;
  logic        fault;
  logic [1:0]  fault_code;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .pc              (pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .id_ready        (id_ready),
    .PCin            (PCin),
    .updatePC        (updatePC),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fe;
    logic [31:0] pc;
    logic        rdy;
    logic [31:0] rdata;
    logic        idr;
  } ins_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        upd;
    logic [31:0] pcin;
    logic        flt;
    logic [1:0]  code;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t got;
    got = '{imem_req, imem_addr, instr_valid, instr, instr_pc, updatePC, PCin, fault, fault_code};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    fetch_en        = 1'b0;
    pc              = '0;
    redirect        = 1'b0;
    redirect_target = '0;
    imem_ready      = 1'b0;
    imem_rdata      = '0;
    id_ready        = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Basic fetch loop: pc=0 then pc=4, zero-wait memory, decode always ready
    vecs[0] = '{'{1'b1, 32'h0, 1'b1, 32'h00A00093, 1'b1}, '{1'b1, 32'h0, 1'b0, 32'h0,        32'h0, 1'b0, 32'h0, 1'b0, 2'b00}};
    vecs[1] = '{'{1'b1, 32'h0, 1'b1, 32'h00A00093, 1'b1}, '{1'b0, 32'h0, 1'b1, 32'h00A00093, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00}};
    vecs[2] = '{'{1'b1, 32'h0, 1'b1, 32'h00A00093, 1'b1}, '{1'b0, 32'h0, 1'b0, 32'h00A00093, 32'h0, 1'b1, 32'h4, 1'b0, 2'b00}};
    vecs[3] = '{'{1'b1, 32'h0, 1'b1, 32'h00A00093, 1'b1}, '{1'b0, 32'h0, 1'b0, 32'h00A00093, 32'h0, 1'b0, 32'h4, 1'b0, 2'b00}};
    vecs[4] = '{'{1'b1, 32'h4, 1'b1, 32'h00100113, 1'b1}, '{1'b1, 32'h4, 1'b0, 32'h00A00093, 32'h0, 1'b0, 32'h4, 1'b0, 2'b00}};
    vecs[5] = '{'{1'b1, 32'h4, 1'b1, 32'h00100113, 1'b1}, '{1'b0, 32'h4, 1'b1, 32'h00100113, 32'h4, 1'b0, 32'h4, 1'b0, 2'b00}};
    vecs[6] = '{'{1'b1, 32'h4, 1'b1, 32'h00100113, 1'b1}, '{1'b0, 32'h4, 1'b0, 32'h00100113, 32'h4, 1'b1, 32'h8, 1'b0, 2'b00}};
    vecs[7] = '{'{1'b0, 32'h4, 1'b1, 32'h00100113, 1'b1}, '{1'b0, 32'h4, 1'b0, 32'h00100113, 32'h4, 1'b0, 32'h8, 1'b0, 2'b00}};
    vecs[8] = '{'{1'b0, 32'h8, 1'b1, 32'h00100113, 1'b1}, '{1'b0, 32'h4, 1'b0, 32'h00100113, 32'h4, 1'b0, 32'h8, 1'b0, 2'b00}};

    do_reset();
    check_outs("reset_state", '0);

    for (int i = 0; i < 9; i++) begin
      fetch_en   = vecs[i].in.fe;
      pc         = vecs[i].in.pc;
      imem_ready = vecs[i].in.rdy;
      imem_rdata = vecs[i].in.rdata;
      id_ready   = vecs[i].in.idr;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Memory wait states, then decode stall
    do_reset();
    fetch_en   = 1'b1;
    pc         = 32'h10;
    imem_ready = 1'b0;
    imem_rdata = 32'h12345678;
    id_ready   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("wait_req_c%0d", k), {31'b0, imem_req}, 32'h1);
      check($sformatf("wait_addr_c%0d", k), imem_addr, 32'h10);
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("wait_no_fault", {31'b0, fault}, 32'h0);
    check("wait_valid", {31'b0, instr_valid}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stall_instr_c%0d", k), instr, 32'h12345678);
      check($sformatf("stall_ipc_c%0d", k), instr_pc, 32'h10);
      check($sformatf("stall_upd_c%0d", k), {31'b0, updatePC}, 32'h0);
    end
    id_ready = 1'b1;
    step();
    check("stall_accept_upd", {31'b0, updatePC}, 32'h1);
    check("stall_accept_pcin", PCin, 32'h14);

    // Redirect while waiting in REQ: returned word is discarded
    do_reset();
    fetch_en   = 1'b1;
    pc         = 32'h8;
    imem_ready = 1'b0;
    id_ready   = 1'b1;
    step();
    redirect        = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect   = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    check("redir_req_valid", {31'b0, instr_valid}, 32'h0);
    check("redir_req_instr", instr, 32'h0);
    check("redir_req_upd", {31'b0, updatePC}, 32'h1);
    check("redir_req_pcin", PCin, 32'h200);
    step();
    check("redir_req_upd_off", {31'b0, updatePC}, 32'h0);

    // Misaligned PC: sticky fault, no request
    do_reset();
    fetch_en   = 1'b1;
    pc         = 32'h6;
    imem_ready = 1'b1;
    step();
    check("misalign_fault", {31'b0, fault}, 32'h1);
    check("misalign_code", {30'b0, fault_code}, 32'h1);
    check("misalign_req", {31'b0, imem_req}, 32'h0);
    pc = 32'h8;
    step();
    step();
    check("misalign_sticky", {31'b0, fault}, 32'h1);
    check("misalign_sticky_req", {31'b0, imem_req}, 32'h0);

    // Memory never answers: timeout after TIMEOUT waiting cycles
    do_reset();
    fetch_en   = 1'b1;
    pc         = 32'h20;
    imem_ready = 1'b0;
    step();
    for (int k = 0; k < 254; k++) step();
    check("timeout_not_yet", {31'b0, fault}, 32'h0);
    check("timeout_req_held", {31'b0, imem_req}, 32'h1);
    step();
    check("timeout_fault", {31'b0, fault}, 32'h1);
    check("timeout_code", {30'b0, fault_code}, 32'h2);
    check("timeout_req_off", {31'b0, imem_req}, 32'h0);

    // Asynchronous reset in the middle of REQ
    do_reset();
    fetch_en   = 1'b1;
    pc         = 32'h30;
    imem_ready = 1'b0;
    step();
    check("areset_pre_req", {31'b0, imem_req}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("areset_req", {31'b0, imem_req}, 32'h0);
    check("areset_addr", imem_addr, 32'h0);
    check("areset_fault", {31'b0, fault}, 32'h0);
    step();
    reset = 1'b1;

    // PC wrap at the top of the address space
    do_reset();
    fetch_en   = 1'b1;
    pc         = 32'hFFFFFFFC;
    imem_ready = 1'b1;
    imem_rdata = 32'h00000013;
    id_ready   = 1'b1;
    step();
    step();
    check("wrap_ipc", instr_pc, 32'hFFFFFFFC);
    step();
    check("wrap_upd", {31'b0, updatePC}, 32'h1);
    check("wrap_pcin", PCin, 32'h0);

    // Redirect during UPD forces a second UPD pass; redirect in IDLE goes to UPD
    do_reset();
    fetch_en   = 1'b1;
    pc         = 32'h40;
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    step();
    step();
    step();
    check("late_first_pcin", PCin, 32'h44);
    redirect        = 1'b1;
    redirect_target = 32'h300;
    step();
    redirect = 1'b0;
    check("late_second_upd", {31'b0, updatePC}, 32'h1);
    check("late_second_pcin", PCin, 32'h300);
    step();
    check("late_upd_off", {31'b0, updatePC}, 32'h0);
    fetch_en        = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h80;
    step();
    redirect = 1'b0;
    check("idle_redir_upd", {31'b0, updatePC}, 32'h1);
    check("idle_redir_pcin", PCin, 32'h80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
